n_to_1_packet_arbiter: RTL and testbench
========================================

// Module: n_to_1_packet_arbiter
// PURPOSE
//  N-input, 1-output wormhole flit merger for the router output stage. Buffers each input in a small FIFO,
//  grants whole packets (HEAD..TAIL or SINGLE) to one output, priority by the header CMP field.
//  Adds round-robin tie-break, age-based starvation guard, stray-flit drop, selectable arbitration mode.
// PARAMETERS
//  N          6   number of input channels (>=2)
//  DEPTH      2   per-input FIFO depth in flits (power of 2, >=2)
//  MODE       0   0 = priority (max CMP field, RR tie-break); 1 = pure round-robin (CMP ignored)
//  AGE_W      4   width of per-input age counter
//  AGE_LIMIT  15  age at which an input overrides priority (<= 2**AGE_W-1)
// PORTS
//  clk        in   1            clock
//  rst        in   1            reset, synchronous, active-high
//  in         in   FLIT_SIZE*N  input flits, channel i at [FLIT_SIZE*i +: FLIT_SIZE]
//  in_valid   in   N            flit on channel i valid
//  in_avail   out  N            channel i FIFO can accept a flit this cycle
//  out        out  FLIT_SIZE    granted flit (head of selected FIFO)
//  out_valid  out  1            out holds a valid flit
//  out_avail  in   1            downstream accepts out this cycle
//  drop_pulse out  1            one-cycle pulse: stray BODY/TAIL flit discarded
// BEHAVIOUR
//  - Flit type = flit[FLIT_SIZE-1 -: HEADER_LEN]; priority key = flit[CMP_POS -: CMP_LEN].
//  - Push: in_valid[i] & in_avail[i]; in_avail[i] = !full[i] & !rst (no full-bypass). Pop: out_valid & out_avail.
//  - Latency: flit pushed in cycle t is earliest on out in cycle t+1; out is combinational from FIFO head.
//  - Candidate i: FIFO i non-empty and head type HEAD or SINGLE.
//  - Unlocked: out_valid = any candidate. Select by, in order:
//    1) any candidate with age==AGE_LIMIT: first such index at/after rr_ptr (circular);
//    2) MODE0: max key among candidates; ties -> first at/after rr_ptr; MODE1: first candidate at/after rr_ptr.
//  - Lock: pop of a HEAD flit sets lock=1, lock_idx=sel; pop of TAIL on lock_idx clears lock. SINGLE never locks.
//  - Locked: sel=lock_idx; out_valid = !empty[lock_idx]; no re-arbitration; other inputs wait (bubbles allowed).
//  - rr_ptr <= sel+1 (mod N) on each pop of a HEAD or SINGLE flit.
//  - Age: per input, on each cycle unlocked & out_avail & out_valid: candidate not granted -> +1 saturating
//    at AGE_LIMIT; granted -> 0; non-candidate -> hold. Ages hold while locked.
//  - Stray flit: unlocked, head of FIFO i is BODY/TAIL -> popped and discarded that cycle (lowest such i, one
//    per cycle, independent of out_avail), drop_pulse=1; never presented on out.
//  - Simultaneous push+pop on same FIFO: both occur; count unchanged. Push to full FIFO impossible.
//  - Reset (any time, incl. mid-packet): FIFOs emptied, lock=0, rr_ptr=0, ages=0; during rst in_avail=0,
//    out_valid=0, drop_pulse=0; out value don't-care. Truncated packet downstream is upstream's concern.
//  - After rst deasserts: in_avail = all ones next evaluation, out_valid=0 until a HEAD/SINGLE arrives.
// STRUCTURE
//  - Shared constants in para.sv: FLIT_SIZE, HEADER_LEN, HEAD_FLIT, BODY_FLIT, TAIL_FLIT, SINGLE_FLIT,
//    CMP_POS, CMP_LEN; add typedef flit_t and enum flit_type_e there.
//  - Sub-module flit_fifo (#(W, DEPTH)): sync FIFO, push/pop/full/empty/head, first-word-fall-through.
//  - Top: N x flit_fifo, arbitration comb block, lock/rr_ptr/age registers.
// TESTING
//  1) MODE0: ch1 SINGLE key 3, ch4 SINGLE key 7 same cycle, out_avail=1 -> ch4 out cycle t+1, ch1 at t+2.
//  2) Wormhole: ch0 HEAD,BODY,TAIL; ch2 SINGLE key max arrives mid-packet -> ch0 flits contiguous, ch2 after TAIL.
//  3) Tie: ch0..ch5 SINGLE equal keys refilled each grant -> grants rotate 0,1,2,3,4,5,0 (rr_ptr).
//  4) Starvation: ch0 key 1 SINGLE, ch3 fed key 9 SINGLEs continuously, AGE_LIMIT=3 -> ch0 granted on 4th arb.
//  5) Backpressure/full: out_avail=0, ch0 gets DEPTH flits -> in_avail[0]=0; out_avail=1 -> drains in order.
//  6) Stray BODY on ch5 unlocked -> drop_pulse one cycle, never on out; rst mid-packet -> all state cleared.

Source files
------------

// File: rtl/n_to_1_packet_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// n_to_1_packet_arbiter_pkg
// Purpose : shared flit format for the router output stage. A flit carries a
//           2-bit type field in its top bits, a 4-bit priority key just below
//           it, and a 10-bit payload in the remaining bits.
// Contents: flit geometry constants, flit_t, flit_type_e, and small helpers
//           that extract the type and key and classify packet-start flits.
// ---------------------------------------------------------------------------
package n_to_1_packet_arbiter_pkg;

   localparam int FLIT_SIZE  = 16;
   localparam int HEADER_LEN = 2;
   localparam int CMP_POS    = 13;
   localparam int CMP_LEN    = 4;

   localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00;
   localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01;
   localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10;
   localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

   typedef logic [FLIT_SIZE-1:0] flit_t;

   typedef enum logic [HEADER_LEN-1:0] {
      FT_HEAD   = HEAD_FLIT,
      FT_BODY   = BODY_FLIT,
      FT_TAIL   = TAIL_FLIT,
      FT_SINGLE = SINGLE_FLIT
   } flit_type_e;

   function automatic flit_type_e flitType(input flit_t f);
      return flit_type_e'(f[FLIT_SIZE-1 -: HEADER_LEN]);
   endfunction

   function automatic logic [CMP_LEN-1:0] flitKey(input flit_t f);
      return f[CMP_POS -: CMP_LEN];
   endfunction

   // A flit may open an arbitration only if it starts a packet.
   function automatic logic isHeaderFlit(input flit_t f);
      return (flitType(f) == FT_HEAD) || (flitType(f) == FT_SINGLE);
   endfunction

endpackage

// File: rtl/n_to_1_packet_arbiter_flit_fifo.sv
// ---------------------------------------------------------------------------
// flit_fifo
// Purpose : small synchronous first-word-fall-through FIFO used to buffer each
//           arbiter input. The oldest entry is always visible on o_head.
// Ports   : clk, rst      clock, synchronous active-high reset (empties FIFO)
//           i_push/i_data write one word (ignored when full)
//           i_pop         discard the head word (ignored when empty)
//           o_full/o_empty occupancy flags
//           o_head        current oldest word, valid when !o_empty
// ---------------------------------------------------------------------------
module flit_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic         o_full,
   output logic         o_empty,
   output logic [W-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wrPtr;
   logic [AW:0]  r_rdPtr;

   // Pointers carry one extra wrap bit so full and empty can be told apart
   // when the address bits coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (i_push && !o_full) begin
            r_wrPtr <= r_wrPtr + (AW+1)'(1);
         end
         if (i_pop && !o_empty) begin
            r_rdPtr <= r_rdPtr + (AW+1)'(1);
         end
      end
   end

   // Storage needs no reset; stale words are never visible once the
   // pointers are cleared.
   always_ff @(posedge clk) begin
      if (i_push && !o_full) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_data;
      end
   end

   assign o_empty = (r_wrPtr == r_rdPtr);
   assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign o_head  = r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/n_to_1_packet_arbiter.sv
// ---------------------------------------------------------------------------
// n_to_1_packet_arbiter
// Purpose : N-input wormhole flit merger. Each input is buffered in a
//           flit_fifo; whole packets (HEAD..TAIL, or a SINGLE) are granted
//           to the one output. Unlocked arbitration picks an aged input
//           first, then the highest key (MODE 0) or plain round-robin
//           (MODE 1), with ties resolved from the round-robin pointer.
//           Stray BODY/TAIL flits at a FIFO head are discarded.
// Ports   : clk, rst      clock, synchronous active-high reset
//           i_in          N flits, channel i at [FLIT_SIZE*i +: FLIT_SIZE]
//           i_inValid     per-channel flit valid
//           o_inAvail     per-channel FIFO can accept a flit
//           o_out         granted flit (combinational from FIFO head)
//           o_outValid    o_out holds a valid flit
//           i_outAvail    downstream accepts o_out this cycle
//           o_dropPulse   one-cycle pulse when a stray flit is discarded
// ---------------------------------------------------------------------------
module n_to_1_packet_arbiter
   import n_to_1_packet_arbiter_pkg::*;
#(
   parameter int N         = 6,
   parameter int DEPTH     = 2,
   parameter int MODE      = 0,
   parameter int AGE_W     = 4,
   parameter int AGE_LIMIT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FLIT_SIZE*N-1:0] i_in,
   input  logic [N-1:0]           i_inValid,
   output logic [N-1:0]           o_inAvail,
   output logic [FLIT_SIZE-1:0]   o_out,
   output logic                   o_outValid,
   input  logic                   i_outAvail,
   output logic                   o_dropPulse
);

   localparam int IW = $clog2(N);

   logic [N-1:0]    w_full;
   logic [N-1:0]    w_empty;
   logic [N-1:0]    w_push;
   logic [N-1:0]    w_pop;
   logic [N-1:0]    w_cand;
   logic [N-1:0]    w_stray;
   flit_t           w_head [N];

   logic            r_lock;
   logic [IW-1:0]   r_lockIdx;
   logic [IW-1:0]   r_rrPtr;
   logic [AGE_W-1:0] r_age [N];

   logic            w_agedFound;
   logic [IW-1:0]   w_agedIdx;
   logic            w_normFound;
   logic [IW-1:0]   w_normIdx;
   logic [CMP_LEN-1:0] w_bestKey;
   logic [IW-1:0]   w_arbIdx;
   logic [IW-1:0]   w_sel;
   logic            w_dropValid;
   logic [IW-1:0]   w_dropIdx;
   logic            w_popOut;
   flit_type_e      w_outType;

   // Index k steps after base, wrapping around the N channels.
   function automatic logic [IW-1:0] circIdx(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N) begin
         s = s - N;
      end
      return IW'(s);
   endfunction

   assign o_inAvail = ~w_full & {N{~rst}};
   assign w_push    = i_inValid & o_inAvail;

   for (genvar g = 0; g < N; g++) begin : g_fifo
      flit_fifo #(.W(FLIT_SIZE), .DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_push  (w_push[g]),
         .i_data  (i_in[FLIT_SIZE*g +: FLIT_SIZE]),
         .i_pop   (w_pop[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g]),
         .o_head  (w_head[g])
      );

      assign w_cand[g]  = !w_empty[g] &&  isHeaderFlit(w_head[g]);
      assign w_stray[g] = !w_empty[g] && !isHeaderFlit(w_head[g]);
      assign w_pop[g]   = (w_popOut && (w_sel == IW'(g))) ||
                          (o_dropPulse && (w_dropIdx == IW'(g)));
   end

   // Unlocked arbitration. Every scan walks the channels starting at the
   // round-robin pointer so that "first found" means first at/after rr_ptr.
   // A starving (aged) candidate beats everything; otherwise the highest key
   // wins in MODE 0, where strict greater-than keeps the earliest of equal
   // keys, or the first candidate wins in MODE 1.
   always_comb begin
      w_agedFound = 1'b0;
      w_agedIdx   = '0;
      w_normFound = 1'b0;
      w_normIdx   = '0;
      w_bestKey   = '0;
      for (int k = 0; k < N; k++) begin
         if (!w_agedFound && w_cand[circIdx(r_rrPtr, k)] &&
             (r_age[circIdx(r_rrPtr, k)] == AGE_W'(AGE_LIMIT))) begin
            w_agedFound = 1'b1;
            w_agedIdx   = circIdx(r_rrPtr, k);
         end
         if (w_cand[circIdx(r_rrPtr, k)]) begin
            if (MODE == 1) begin
               if (!w_normFound) begin
                  w_normFound = 1'b1;
                  w_normIdx   = circIdx(r_rrPtr, k);
               end
            end else if (!w_normFound ||
                         (flitKey(w_head[circIdx(r_rrPtr, k)]) > w_bestKey)) begin
               w_normFound = 1'b1;
               w_normIdx   = circIdx(r_rrPtr, k);
               w_bestKey   = flitKey(w_head[circIdx(r_rrPtr, k)]);
            end
         end
      end
      w_arbIdx = w_agedFound ? w_agedIdx : w_normIdx;
   end

   // Stray flits are found lowest index first, one discarded per cycle.
   always_comb begin
      w_dropValid = 1'b0;
      w_dropIdx   = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (w_stray[i]) begin
            w_dropValid = 1'b1;
            w_dropIdx   = IW'(i);
         end
      end
   end

   // While a packet is in flight the locked channel owns the output, even
   // if its FIFO momentarily runs dry; no other channel may interleave.
   assign w_sel       = r_lock ? r_lockIdx : w_arbIdx;
   assign o_outValid  = !rst && (r_lock ? !w_empty[r_lockIdx] : (|w_cand));
   assign o_out       = w_head[w_sel];
   assign o_dropPulse = !rst && !r_lock && w_dropValid;
   assign w_popOut    = o_outValid && i_outAvail;
   assign w_outType   = flitType(o_out);

   // Packet lock, round-robin pointer and starvation ages. Ages only move
   // on cycles where an unlocked grant is actually accepted downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock    <= 1'b0;
         r_lockIdx <= '0;
         r_rrPtr   <= '0;
         for (int i = 0; i < N; i++) begin
            r_age[i] <= '0;
         end
      end else begin
         if (w_popOut) begin
            if (w_outType == FT_HEAD) begin
               r_lock    <= 1'b1;
               r_lockIdx <= w_sel;
            end else if (w_outType == FT_TAIL) begin
               r_lock    <= 1'b0;
            end
            if ((w_outType == FT_HEAD) || (w_outType == FT_SINGLE)) begin
               r_rrPtr <= circIdx(w_sel, 1);
            end
         end
         if (!r_lock && w_popOut) begin
            for (int i = 0; i < N; i++) begin
               if (IW'(i) == w_sel) begin
                  r_age[i] <= '0;
               end else if (w_cand[i] && (r_age[i] < AGE_W'(AGE_LIMIT))) begin
                  r_age[i] <= r_age[i] + AGE_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_n_to_1_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_n_to_1_packet_arbiter
// Purpose : directed self-checking bench for n_to_1_packet_arbiter with
//           N=6, DEPTH=2, MODE=0, AGE_LIMIT=3. Expected flits are built with
//           mkFlit from hand-worked schedules; payload encodes channel*16+seq.
// ---------------------------------------------------------------------------
module tb_n_to_1_packet_arbiter;
   import n_to_1_packet_arbiter_pkg::*;

   localparam int N = 6;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [FLIT_SIZE*N-1:0] inBus;
   logic [N-1:0]           inValid;
   logic [N-1:0]           inAvail;
   flit_t                  outFlit;
   logic                   outValid;
   logic                   outAvail;
   logic                   dropPulse;

   int total = 0;
   int bad   = 0;

   n_to_1_packet_arbiter #(
      .N(N), .DEPTH(2), .MODE(0), .AGE_W(4), .AGE_LIMIT(3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_in        (inBus),
      .i_inValid   (inValid),
      .o_inAvail   (inAvail),
      .o_out       (outFlit),
      .o_outValid  (outValid),
      .i_outAvail  (outAvail),
      .o_dropPulse (dropPulse)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic flit_t mkFlit(input flit_type_e t, input logic [3:0] key,
                                    input int ch, input int seq);
      return {t, key, 10'(ch*16 + seq)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int ch, input flit_t f);
      inBus[ch*FLIT_SIZE +: FLIT_SIZE] = f;
      inValid[ch] = 1'b1;
   endtask

   // Step one clock; valids are dropped just after the edge and outputs are
   // settled by the time the caller samples (4 ns after the edge).
   task automatic advance();
      @(posedge clk);
      #1;
      inValid = '0;
      #3;
   endtask

   task automatic doReset();
      rst      = 1'b1;
      inValid  = '0;
      outAvail = 1'b0;
      advance();
      checkOutput("rst inAvail", 32'(inAvail), 32'(6'b000000));
      checkOutput("rst outValid", 32'(outValid), 32'd0);
      checkOutput("rst drop", 32'(dropPulse), 32'd0);
      advance();
      rst = 1'b0;
      advance();
      checkOutput("post-rst inAvail", 32'(inAvail), 32'(6'b111111));
      checkOutput("post-rst outValid", 32'(outValid), 32'd0);
   endtask

   initial begin
      inBus = '0;
      // Priority: higher key on ch4 beats ch1 in the same cycle.
      doReset();
      outAvail = 1'b1;
      applyStimulus(1, mkFlit(FT_SINGLE, 4'd3, 1, 0));
      applyStimulus(4, mkFlit(FT_SINGLE, 4'd7, 4, 0));
      checkOutput("prio idle", 32'(outValid), 32'd0);
      advance();
      checkOutput("prio valid1", 32'(outValid), 32'd1);
      checkOutput("prio first", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd7, 4, 0)));
      advance();
      checkOutput("prio second", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd3, 1, 0)));
      advance();
      checkOutput("prio empty", 32'(outValid), 32'd0);

      // Wormhole: ch2 max-key SINGLE must wait for ch0's TAIL.
      doReset();
      outAvail = 1'b1;
      applyStimulus(0, mkFlit(FT_HEAD, 4'd1, 0, 0));
      advance();
      checkOutput("worm head", 32'(outFlit), 32'(mkFlit(FT_HEAD, 4'd1, 0, 0)));
      applyStimulus(0, mkFlit(FT_BODY, 4'd0, 0, 1));
      advance();
      checkOutput("worm body", 32'(outFlit), 32'(mkFlit(FT_BODY, 4'd0, 0, 1)));
      applyStimulus(0, mkFlit(FT_TAIL, 4'd0, 0, 2));
      applyStimulus(2, mkFlit(FT_SINGLE, 4'd15, 2, 0));
      advance();
      checkOutput("worm tail", 32'(outFlit), 32'(mkFlit(FT_TAIL, 4'd0, 0, 2)));
      advance();
      checkOutput("worm after", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd15, 2, 0)));
      advance();
      checkOutput("worm idle", 32'(outValid), 32'd0);

      // Tie: all channels hold two equal-key SINGLEs; grants rotate.
      doReset();
      for (int ch = 0; ch < N; ch++) applyStimulus(ch, mkFlit(FT_SINGLE, 4'd5, ch, 0));
      advance();
      for (int ch = 0; ch < N; ch++) applyStimulus(ch, mkFlit(FT_SINGLE, 4'd5, ch, 1));
      advance();
      checkOutput("tie full", 32'(inAvail), 32'(6'b000000));
      checkOutput("tie valid", 32'(outValid), 32'd1);
      outAvail = 1'b1;
      for (int i = 0; i < 7; i++) begin
         checkOutput($sformatf("tie grant%0d", i), 32'(outFlit),
                     32'(mkFlit(FT_SINGLE, 4'd5, i % N, i / N)));
         advance();
      end

      // Starvation: ch0 key 1 against a stream of key 9 on ch3.
      doReset();
      outAvail = 1'b1;
      applyStimulus(0, mkFlit(FT_SINGLE, 4'd1, 0, 0));
      applyStimulus(3, mkFlit(FT_SINGLE, 4'd9, 3, 0));
      advance();
      for (int i = 1; i <= 3; i++) begin
         checkOutput($sformatf("starve arb%0d", i), 32'(outFlit),
                     32'(mkFlit(FT_SINGLE, 4'd9, 3, i-1)));
         applyStimulus(3, mkFlit(FT_SINGLE, 4'd9, 3, i));
         advance();
      end
      checkOutput("starve aged", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd1, 0, 0)));
      advance();
      checkOutput("starve resume", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd9, 3, 3)));
      advance();
      checkOutput("starve idle", 32'(outValid), 32'd0);

      // Backpressure: fill ch0, hold, then drain in order.
      doReset();
      applyStimulus(0, mkFlit(FT_SINGLE, 4'd2, 0, 0));
      advance();
      applyStimulus(0, mkFlit(FT_SINGLE, 4'd2, 0, 1));
      advance();
      checkOutput("bp full", 32'(inAvail), 32'(6'b111110));
      checkOutput("bp head", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd2, 0, 0)));
      advance();
      checkOutput("bp hold", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd2, 0, 0)));
      checkOutput("bp holdvalid", 32'(outValid), 32'd1);
      outAvail = 1'b1;
      advance();
      checkOutput("bp drain", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd2, 0, 1)));
      checkOutput("bp avail", 32'(inAvail), 32'(6'b111111));
      advance();
      checkOutput("bp idle", 32'(outValid), 32'd0);

      // Stray BODY on ch5 is dropped with a single pulse.
      doReset();
      applyStimulus(5, mkFlit(FT_BODY, 4'd15, 5, 0));
      advance();
      checkOutput("stray pulse", 32'(dropPulse), 32'd1);
      checkOutput("stray noout", 32'(outValid), 32'd0);
      advance();
      checkOutput("stray pulse end", 32'(dropPulse), 32'd0);
      checkOutput("stray gone", 32'(outValid), 32'd0);

      // Reset in the middle of a locked packet clears everything.
      outAvail = 1'b1;
      applyStimulus(1, mkFlit(FT_HEAD, 4'd2, 1, 0));
      advance();
      checkOutput("mid head", 32'(outFlit), 32'(mkFlit(FT_HEAD, 4'd2, 1, 0)));
      applyStimulus(1, mkFlit(FT_BODY, 4'd0, 1, 1));
      applyStimulus(2, mkFlit(FT_SINGLE, 4'd15, 2, 0));
      advance();
      checkOutput("mid body", 32'(outFlit), 32'(mkFlit(FT_BODY, 4'd0, 1, 1)));
      rst = 1'b1;
      applyStimulus(3, mkFlit(FT_SINGLE, 4'd4, 3, 0));
      advance();
      checkOutput("mid rst inAvail", 32'(inAvail), 32'(6'b000000));
      checkOutput("mid rst outValid", 32'(outValid), 32'd0);
      checkOutput("mid rst drop", 32'(dropPulse), 32'd0);
      rst = 1'b0;
      advance();
      checkOutput("mid cleared", 32'(outValid), 32'd0);
      checkOutput("mid inAvail", 32'(inAvail), 32'(6'b111111));
      checkOutput("mid nodrop", 32'(dropPulse), 32'd0);
      applyStimulus(2, mkFlit(FT_SINGLE, 4'd6, 2, 1));
      advance();
      checkOutput("mid unlocked", 32'(outFlit), 32'(mkFlit(FT_SINGLE, 4'd6, 2, 1)));
      checkOutput("mid unlocked v", 32'(outValid), 32'd1);
      advance();
      checkOutput("mid idle", 32'(outValid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
